// File: rtl/tile_renderer.sv
// tile_renderer: 32x30 character-cell renderer driven by the sync generator.
// Each 8x8 cell is fetched one cell ahead: char byte, attribute byte, then
// font row. The fetched row waits in pending_* until the load point, where
// it moves into the pixel shift register. rgb/hsync/vsync share one cycle
// of delay so they stay aligned with each other.
module tile_renderer #(
  parameter int H_DISPLAY = 256,
  parameter int V_DISPLAY = 240,
  parameter int H_MAX     = 308,
  parameter int V_MAX     = 261
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [8:0]  hpos,
  input  logic [8:0]  vpos,
  input  logic        display_on,
  input  logic        hsync_in,
  input  logic        vsync_in,
  output logic [10:0] vram_addr,
  output logic        vram_rd,
  input  logic [7:0]  vram_data,
  output logic [10:0] font_addr,
  input  logic [7:0]  font_data,
  output logic [2:0]  rgb,
  output logic        hsync,
  output logic        vsync
);

  localparam logic [8:0] H_PREFETCH  = 9'(H_MAX - 7);
  localparam logic [8:0] H_LAST      = 9'(H_MAX);
  localparam logic [8:0] V_LAST      = 9'(V_MAX);
  localparam logic [8:0] H_FETCH_LIM = 9'(H_DISPLAY - 8);
  localparam logic [8:0] H_LOAD_LIM  = 9'(H_DISPLAY - 1);
  localparam logic [9:0] V_LIM       = 10'(V_DISPLAY);

  // State names the byte arriving on the read data bus this cycle:
  // S_CHAR = char byte (s+1), S_ATTR = attr byte (s+2), S_FONT = font byte (s+3).
  typedef enum logic [2:0] {S_IDLE, S_CHAR, S_ATTR, S_FONT, S_WAIT} state_t;

  state_t      state;
  logic [10:0] addr_q;
  logic        rd_q;
  logic [2:0]  frow_q;
  logic [5:0]  attr_q;
  logic [7:0]  pending_bits;
  logic [5:0]  pending_attr;
  logic [7:0]  shift;
  logic [5:0]  cur_attr;

  logic        trig_eol;
  logic        trig_cell;
  logic        fetch_go;
  logic        load;
  logic [9:0]  tl;
  logic [4:0]  col;

  // Decode fetch triggers, target line/column and load events from the beam.
  always_comb begin
    trig_eol  = (hpos == H_PREFETCH);
    trig_cell = (hpos[2:0] == 3'd0) && (hpos < H_FETCH_LIM);
    if (trig_eol) begin
      tl  = (vpos == V_LAST) ? 10'd0 : {1'b0, vpos} + 10'd1;
      col = 5'd0;
    end else begin
      tl  = {1'b0, vpos};
      col = hpos[7:3] + 5'd1;
    end
    fetch_go = reset && (trig_eol || trig_cell) && (tl < V_LIM) &&
               ((state == S_IDLE) || (state == S_WAIT));
    load = (hpos == H_LAST) || ((hpos[2:0] == 3'd7) && (hpos < H_LOAD_LIM));
  end

  // The char address must be on the bus in the trigger cycle itself, since the
  // trigger is only known from this cycle's hpos; later addresses are registered.
  assign vram_rd   = fetch_go | rd_q;
  assign vram_addr = fetch_go ? {1'b0, tl[7:3], col} : addr_q;

  // Fetch sequencer: char -> attr -> font, then hold the result until loaded.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= S_IDLE;
      addr_q       <= 11'd0;
      rd_q         <= 1'b0;
      frow_q       <= 3'd0;
      attr_q       <= 6'd0;
      font_addr    <= 11'd0;
      pending_bits <= 8'd0;
      pending_attr <= 6'd0;
    end else if (fetch_go) begin
      addr_q <= {1'b1, tl[7:3], col};
      rd_q   <= 1'b1;
      frow_q <= tl[2:0];
      state  <= S_CHAR;
    end else begin
      case (state)
        S_CHAR: begin
          font_addr <= {vram_data, frow_q};
          rd_q      <= 1'b0;
          state     <= S_ATTR;
        end
        S_ATTR: begin
          attr_q <= vram_data[5:0];
          state  <= S_FONT;
        end
        S_FONT: begin
          pending_bits <= font_data;
          pending_attr <= attr_q;
          state        <= S_WAIT;
        end
        S_WAIT:  if (load) state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // Pixel shifter and delay-matched colour/sync outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      shift    <= 8'd0;
      cur_attr <= 6'd0;
      rgb      <= 3'd0;
      hsync    <= 1'b0;
      vsync    <= 1'b0;
    end else begin
      if (load) begin
        shift    <= pending_bits;
        cur_attr <= pending_attr;
      end else begin
        shift <= {shift[6:0], 1'b0};
      end
      rgb   <= display_on ? (shift[7] ? cur_attr[5:3] : cur_attr[2:0]) : 3'd0;
      hsync <= hsync_in;
      vsync <= vsync_in;
    end
  end

endmodule
